// File: rtl/bomb_object_drawer_if.sv
// Signal bundle between a bomb drawer and its environment (placement, scan position, draw/status outputs).
// With BOMB_REMOTE_DETONATE_EN defined the bundle also carries the remote detonate request.
interface bomb_object_drawer_if;
  logic        startOfFrame;
  logic        placeBomb;
  logic [10:0] placeX;
  logic [10:0] placeY;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
`ifdef BOMB_REMOTE_DETONATE_EN
  logic        detonate;
`endif
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        busy;
  logic        exploding;
  logic        explodeStart;

  modport master (
`ifdef BOMB_REMOTE_DETONATE_EN
    output detonate,
`endif
    output startOfFrame, placeBomb, placeX, placeY, pixelX, pixelY,
    input  drawingRequest, RGBout, busy, exploding, explodeStart
  );

  modport slave (
`ifdef BOMB_REMOTE_DETONATE_EN
    input  detonate,
`endif
    input  startOfFrame, placeBomb, placeX, placeY, pixelX, pixelY,
    output drawingRequest, RGBout, busy, exploding, explodeStart
  );
endinterface

// File: rtl/bomb_object_drawer.sv
// Single-bomb VGA drawer: tile-snapped placement, frame-counted fuse with blink, cross-shaped blast.
// Optional BOMB_REMOTE_DETONATE_EN adds a detonate input that cuts the fuse short.
module bomb_object_drawer #(
  parameter int         TILE_LOG2    = 5,
  parameter int         FUSE_FRAMES  = 120,
  parameter int         BLINK_FRAMES = 8,
  parameter int         BLAST_FRAMES = 30,
  parameter int         BLAST_RANGE  = 2,
  parameter logic [7:0] BOMB_RGB     = 8'h49,
  parameter logic [7:0] FLASH_RGB    = 8'hFF,
  parameter logic [7:0] BLAST_RGB    = 8'hF0
) (
  input logic                   clk,
  input logic                   resetN,
  bomb_object_drawer_if.slave   io_bomb
);

  localparam int TW    = 11 - TILE_LOG2;
  localparam int CNT_W = $clog2((FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES) + 1;
  localparam int BLINK_START = (3 * FUSE_FRAMES) / 4;
  localparam logic signed [TW:0] RANGE_S = (TW+1)'(BLAST_RANGE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FUSE = 2'd1, S_BLAST = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_frame_cnt, w_cnt_nxt;
  logic [TW-1:0]     r_tile_x, r_tile_y, w_tile_x_nxt, w_tile_y_nxt;
  logic              w_explode_nxt;
  logic              r_draw, r_busy, r_exploding, r_explode_start;
  logic [7:0]        r_rgb;
  logic              w_hit;
  logic [7:0]        w_rgb;
  logic              w_detonate;
  logic [TW-1:0]     w_px_t, w_py_t;
  logic signed [TW:0] w_dx, w_dy, w_adx, w_ady;
  logic              w_on_tile, w_in_arm, w_flash;

`ifdef BOMB_REMOTE_DETONATE_EN
  assign w_detonate = io_bomb.detonate;
`else
  assign w_detonate = 1'b0;
`endif

  assign w_px_t = TW'(io_bomb.pixelX >> TILE_LOG2);
  assign w_py_t = TW'(io_bomb.pixelY >> TILE_LOG2);

  // Zero-extended signed differences keep arms near tile 0 from wrapping to high tiles
  assign w_dx  = $signed({1'b0, w_px_t}) - $signed({1'b0, r_tile_x});
  assign w_dy  = $signed({1'b0, w_py_t}) - $signed({1'b0, r_tile_y});
  assign w_adx = w_dx[TW] ? -w_dx : w_dx;
  assign w_ady = w_dy[TW] ? -w_dy : w_dy;

  assign w_on_tile = (w_px_t == r_tile_x) && (w_py_t == r_tile_y);
  assign w_in_arm  = ((w_dy == {(TW+1){1'b0}}) && (w_adx <= RANGE_S)) ||
                     ((w_dx == {(TW+1){1'b0}}) && (w_ady <= RANGE_S));
  assign w_flash   = (r_frame_cnt >= CNT_W'(BLINK_START)) &&
                     (((r_frame_cnt / CNT_W'(BLINK_FRAMES)) & CNT_W'(1)) != {CNT_W{1'b0}});

  // State register plus registered draw and status outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state         <= S_IDLE;
      r_frame_cnt     <= {CNT_W{1'b0}};
      r_tile_x        <= {TW{1'b0}};
      r_tile_y        <= {TW{1'b0}};
      r_draw          <= 1'b0;
      r_rgb           <= 8'h00;
      r_busy          <= 1'b0;
      r_exploding     <= 1'b0;
      r_explode_start <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_frame_cnt     <= w_cnt_nxt;
      r_tile_x        <= w_tile_x_nxt;
      r_tile_y        <= w_tile_y_nxt;
      r_draw          <= w_hit;
      r_rgb           <= w_rgb;
      r_busy          <= (w_state_nxt != S_IDLE);
      r_exploding     <= (w_state_nxt == S_BLAST);
      r_explode_start <= w_explode_nxt;
    end
  end

  // Next-state, frame counter and placement latch
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_frame_cnt;
    w_tile_x_nxt  = r_tile_x;
    w_tile_y_nxt  = r_tile_y;
    w_explode_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bomb.placeBomb) begin
          w_state_nxt  = S_FUSE;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_tile_x_nxt = TW'(io_bomb.placeX >> TILE_LOG2);
          w_tile_y_nxt = TW'(io_bomb.placeY >> TILE_LOG2);
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      S_FUSE: begin
        if (w_detonate ||
            (io_bomb.startOfFrame && (r_frame_cnt == CNT_W'(FUSE_FRAMES - 1)))) begin
          w_state_nxt   = S_BLAST;
          w_cnt_nxt     = {CNT_W{1'b0}};
          w_explode_nxt = 1'b1;
        end else if (io_bomb.startOfFrame) begin
          w_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = r_frame_cnt;
        end
      end
      S_BLAST: begin
        if (io_bomb.startOfFrame && (r_frame_cnt == CNT_W'(BLAST_FRAMES - 1))) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (io_bomb.startOfFrame) begin
          w_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = r_frame_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Pixel hit and colour for the current scan position
  always_comb begin
    w_hit = 1'b0;
    w_rgb = 8'h00;
    case (r_state)
      S_FUSE: begin
        if (w_on_tile) begin
          w_hit = 1'b1;
          w_rgb = w_flash ? FLASH_RGB : BOMB_RGB;
        end else begin
          w_hit = 1'b0;
        end
      end
      S_BLAST: begin
        if (w_in_arm) begin
          w_hit = 1'b1;
          w_rgb = BLAST_RGB;
        end else begin
          w_hit = 1'b0;
        end
      end
      default: begin
        w_hit = 1'b0;
        w_rgb = 8'h00;
      end
    endcase
  end

  assign io_bomb.drawingRequest = r_draw;
  assign io_bomb.RGBout         = r_rgb;
  assign io_bomb.busy           = r_busy;
  assign io_bomb.exploding      = r_exploding;
  assign io_bomb.explodeStart   = r_explode_start;

endmodule
